mux_out_monitor: RTL

//  Downstream consumer of the 4:1 select-mux stage. Samples mux output y each clk over a

---
 rtl/mux_out_monitor_pkg.sv | 20 ++
 rtl/mux_out_monitor_if.sv | 41 ++++
 rtl/mux_out_monitor_sat_counter.sv | 39 +++
 rtl/mux_out_monitor.sv | 110 +++++++++++
 4 files changed

// File: rtl/mux_out_monitor_pkg.sv
// rtl/mux_out_monitor_pkg.sv - shared types and helpers for the mux output monitor
//
// Purpose : FSM state encoding and the golden 4:1 select used by the monitor.
// Contents: state_t     - IDLE / RUN / REPORT encoding
//           golden_sel  - returns i[sel] for a packed {i3,i2,i1,i0} vector
package mux_out_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int unsigned MUX_WAYS = 4;

  function automatic logic golden_sel(input logic [1:0] sel, input logic [MUX_WAYS-1:0] i);
    return i[sel];
  endfunction

endpackage

// File: rtl/mux_out_monitor_if.sv
// rtl/mux_out_monitor_if.sv - control, sample and result signals of the mux output monitor
//
// Purpose : groups the window control, the observed mux signals and the result handshake.
// Signals : start, win_len        window control (driver -> monitor)
//           sel, i0..i3, y        observed mux select, data inputs and output
//           res_ready             result accept (driver -> monitor)
//           busy, res_valid       status (monitor -> driver)
//           mism_cnt, ones_cnt    saturating result counters
//           sat                   sticky saturation flag
// Modports: master = driver/consumer side, slave = monitor side.
interface mux_out_monitor_if #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
);

  logic             start;
  logic [WIN_W-1:0] win_len;
  logic [1:0]       sel;
  logic             i0;
  logic             i1;
  logic             i2;
  logic             i3;
  logic             y;
  logic             res_ready;
  logic             busy;
  logic             res_valid;
  logic [CNT_W-1:0] mism_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic             sat;

  modport master (
    output start, win_len, sel, i0, i1, i2, i3, y, res_ready,
    input  busy, res_valid, mism_cnt, ones_cnt, sat
  );

  modport slave (
    input  start, win_len, sel, i0, i1, i2, i3, y, res_ready,
    output busy, res_valid, mism_cnt, ones_cnt, sat
  );

endinterface

// File: rtl/mux_out_monitor_sat_counter.sv
// rtl/mux_out_monitor_sat_counter.sv - saturating up-counter with saturation-hit strobe
//
// Purpose : counts increment requests, holding at 2^W-1 instead of wrapping.
// Ports   : clk, reset   clock, asynchronous active-high reset
//           i_clr        synchronous clear (wins over i_inc)
//           i_inc        increment request
//           o_count      current count
//           o_sat_hit    increment requested while already at max
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_sat_hit
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max  = (r_count == MAX);
  assign o_count   = r_count;
  assign o_sat_hit = i_inc && w_at_max && !i_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/mux_out_monitor.sv
// rtl/mux_out_monitor.sv - windowed checker of a 4:1 select-mux output against i[sel]
//
// Purpose : over a window of win_len samples (0 treated as 1) counts cycles where
//           y != i[sel] and cycles where y == 1, then offers the result on a
//           valid/ready handshake.
// Ports   : clk, reset   clock, asynchronous active-high reset
//           mon          mux_out_monitor_if.slave (control, samples, results)
module mux_out_monitor
  import mux_out_monitor_pkg::*;
#(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  mux_out_monitor_if.slave mon
);

  state_t           r_state;
  state_t           w_next;
  logic [WIN_W-1:0] r_remain;
  logic             r_sat;

  logic             w_start_ok;
  logic             w_sample;
  logic             w_last;
  logic             w_golden;
  logic             w_inc_mism;
  logic             w_inc_ones;
  logic             w_hit_mism;
  logic             w_hit_ones;
  logic [CNT_W-1:0] w_mism_cnt;
  logic [CNT_W-1:0] w_ones_cnt;
  logic [WIN_W-1:0] w_len;

  // start is only honoured from IDLE; in RUN/REPORT it is dropped silently.
  assign w_start_ok = (r_state == ST_IDLE) && mon.start;
  assign w_sample   = (r_state == ST_RUN);
  assign w_last     = w_sample && (r_remain == WIN_W'(1));
  assign w_len      = (mon.win_len == '0) ? WIN_W'(1) : mon.win_len;

  assign w_golden   = golden_sel(mon.sel, {mon.i3, mon.i2, mon.i1, mon.i0});
  assign w_inc_mism = w_sample && (mon.y != w_golden);
  assign w_inc_ones = w_sample && mon.y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (mon.start)     w_next = ST_RUN;
      ST_RUN:    if (w_last)        w_next = ST_REPORT;
      ST_REPORT: if (mon.res_ready) w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  // Remaining samples in the window; reaching 1 in RUN marks the final sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remain <= '0;
    end else if (w_start_ok) begin
      r_remain <= w_len;
    end else if (w_sample) begin
      r_remain <= r_remain - WIN_W'(1);
    end
  end

  // Sticky until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (w_start_ok) begin
      r_sat <= 1'b0;
    end else if (w_hit_mism || w_hit_ones) begin
      r_sat <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_mism_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_start_ok),
    .i_inc     (w_inc_mism),
    .o_count   (w_mism_cnt),
    .o_sat_hit (w_hit_mism)
  );

  sat_counter #(.W(CNT_W)) u_ones_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_start_ok),
    .i_inc     (w_inc_ones),
    .o_count   (w_ones_cnt),
    .o_sat_hit (w_hit_ones)
  );

  assign mon.busy      = (r_state != ST_IDLE);
  assign mon.res_valid = (r_state == ST_REPORT);
  assign mon.mism_cnt  = w_mism_cnt;
  assign mon.ones_cnt  = w_ones_cnt;
  assign mon.sat       = r_sat;

endmodule
